accelerator_wb_master: RTL and testbench

Bus initiator that drives one multiply transaction into the accelerator register slave on behalf of a local requester. On a `start_i` request it latches two 16-bit operands, writes them to REG_A and REG_B, waits a fixed settle time, then reads REG_RESULT and REG_STATUS. It returns the result and overflow flag with a one-cycle `done_o` pulse. It sits between a local controller (test sequencer or CPU-side glue) and the accelerator's register port.

---
 rtl/accelerator_pkg.sv | 30 +++
 rtl/accelerator_wb_master.sv | 167 ++++++++++++++++
 tb/tb_accelerator_wb_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
// Shared definitions for the multiply accelerator register port:
// register map and the bus master's state encoding.
package accelerator_pkg;

    localparam logic [7:0] ACC_ADDR_A      = 8'h00;
    localparam logic [7:0] ACC_ADDR_B      = 8'h04;
    localparam logic [7:0] ACC_ADDR_RESULT = 8'h08;
    localparam logic [7:0] ACC_ADDR_STATUS = 8'h0c;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_A    = 3'd1,
        ST_WR_B    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_RES  = 3'd4,
        ST_RD_STAT = 3'd5,
        ST_DONE    = 3'd6
    } acc_mst_state_t;

    // True for every state in which a transaction occupies the bus.
    function automatic logic state_is_busy(input acc_mst_state_t st);
        logic busy;
        case (st)
            ST_WR_A, ST_WR_B, ST_WAIT, ST_RD_RES, ST_RD_STAT: busy = 1'b1;
            default:                                          busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/accelerator_wb_master.sv
// Drives one multiply transaction into the accelerator register slave:
// write A, write B, settle, read result, read status, pulse done.
module accelerator_wb_master
    import accelerator_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        wb_rst_n,
    input  logic        start_i,
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] result_o,
    output logic        overflow_o,
    output logic [7:0]  wb_addr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_re_o
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    acc_mst_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      op_a_q, op_a_d;
    logic [15:0]      op_b_q, op_b_d;
    logic [15:0]      result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       addr_q, addr_d;
    logic [31:0]      dat_q, dat_d;
    logic             we_q, we_d;
    logic             re_q, re_d;

    // Only the low half of the read bus carries information.
    logic unused_rd_upper_s;
    assign unused_rd_upper_s = ^wb_dat_i[31:16];

    // Next-state, capture and operand-latch logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_WR_A;
                    op_a_d  = op_a_i;
                    op_b_d  = op_b_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A: state_d = ST_WR_B;
            ST_WR_B: begin
                if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_RD_RES;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RD_RES;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_RES: begin
                result_d = wb_dat_i[15:0];
                state_d  = ST_RD_STAT;
            end
            ST_RD_STAT: begin
                overflow_d = wb_dat_i[0];
                state_d    = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and status outputs decoded from the next state so they register alongside it.
    always_comb begin
        addr_d = 8'h00;
        dat_d  = 32'h0000_0000;
        we_d   = 1'b0;
        re_d   = 1'b0;
        case (state_d)
            ST_WR_A: begin
                addr_d = ACC_ADDR_A;
                dat_d  = {16'h0000, op_a_d};
                we_d   = 1'b1;
            end
            ST_WR_B: begin
                addr_d = ACC_ADDR_B;
                dat_d  = {16'h0000, op_b_d};
                we_d   = 1'b1;
            end
            ST_RD_RES: begin
                addr_d = ACC_ADDR_RESULT;
                re_d   = 1'b1;
            end
            ST_RD_STAT: begin
                addr_d = ACC_ADDR_STATUS;
                re_d   = 1'b1;
            end
            default: begin
                addr_d = 8'h00;
                dat_d  = 32'h0000_0000;
                we_d   = 1'b0;
                re_d   = 1'b0;
            end
        endcase
        busy_d = state_is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_a_q     <= 16'h0000;
            op_b_q     <= 16'h0000;
            result_q   <= 16'h0000;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= 8'h00;
            dat_q      <= 32'h0000_0000;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            re_q       <= re_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;
    assign wb_addr_o  = addr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_re_o    = re_q;

endmodule

// File: tb/tb_accelerator_wb_master.sv
// Bench: two masters (settle 2 and settle 0) share stimulus, each paired
// with a behavioural multiply slave and checked against a cycle-count model.
module tb_accelerator_wb_master;
    import accelerator_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_rst_n;
    logic        start_i;
    logic [15:0] op_a_i, op_b_i;

    logic        busy_s [2];
    logic        done_s [2];
    logic        ovf_s  [2];
    logic        we_s   [2];
    logic        re_s   [2];
    logic [15:0] res_s  [2];
    logic [7:0]  addr_s [2];
    logic [31:0] wdat_s [2];
    logic [31:0] rdat_s [2];

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    accelerator_wb_master #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .wb_rst_n(wb_rst_n), .start_i(start_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i),
        .busy_o(busy_s[0]), .done_o(done_s[0]), .result_o(res_s[0]), .overflow_o(ovf_s[0]),
        .wb_addr_o(addr_s[0]), .wb_dat_o(wdat_s[0]), .wb_dat_i(rdat_s[0]),
        .wb_we_o(we_s[0]), .wb_re_o(re_s[0])
    );

    accelerator_wb_master #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .wb_rst_n(wb_rst_n), .start_i(start_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i),
        .busy_o(busy_s[1]), .done_o(done_s[1]), .result_o(res_s[1]), .overflow_o(ovf_s[1]),
        .wb_addr_o(addr_s[1]), .wb_dat_o(wdat_s[1]), .wb_dat_i(rdat_s[1]),
        .wb_we_o(we_s[1]), .wb_re_o(re_s[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] prod32(input logic [15:0] a, input logic [15:0] b);
        return {16'h0000, a} * {16'h0000, b};
    endfunction

    // Behavioural slave: upper read bits carry junk that the master must ignore.
    logic [15:0] sl_a [2];
    logic [15:0] sl_b [2];

    function automatic logic [31:0] slave_read(input logic [15:0] a, input logic [15:0] b,
                                               input logic [7:0] addr);
        logic [31:0] p;
        p = prod32(a, b);
        case (addr)
            ACC_ADDR_RESULT: return {16'hDEAD, p[15:0]};
            ACC_ADDR_STATUS: return {16'hBEEF, 15'h0000, (p > 32'h0000_FFFF)};
            default:         return 32'h0000_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we_s[i] && addr_s[i] == ACC_ADDR_A) sl_a[i] <= wdat_s[i][15:0];
            if (we_s[i] && addr_s[i] == ACC_ADDR_B) sl_b[i] <= wdat_s[i][15:0];
        end
    end

    assign rdat_s[0] = slave_read(sl_a[0], sl_b[0], addr_s[0]);
    assign rdat_s[1] = slave_read(sl_a[1], sl_b[1], addr_s[1]);

    // Model: m_k = cycles since accept (0 = no transaction), L = 5 + W.
    int          m_k   [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_b   [2];
    logic [15:0] m_res [2];
    logic        m_ovf [2];

    always @(posedge clk or negedge wb_rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!wb_rst_n) begin
                m_k[i] <= 0; m_a[i] <= 16'h0; m_b[i] <= 16'h0;
                m_res[i] <= 16'h0; m_ovf[i] <= 1'b0;
            end else if ((m_k[i] == 0 || m_k[i] == 5 + wc(i)) && start_i) begin
                m_k[i] <= 1; m_a[i] <= op_a_i; m_b[i] <= op_b_i;
            end else if (m_k[i] > 0 && m_k[i] < 5 + wc(i)) begin
                if (m_k[i] == 3 + wc(i)) m_res[i] <= prod32(m_a[i], m_b[i]) & 32'h0000_FFFF;
                if (m_k[i] == 4 + wc(i)) m_ovf[i] <= (prod32(m_a[i], m_b[i]) > 32'h0000_FFFF);
                m_k[i] <= m_k[i] + 1;
            end else begin
                m_k[i] <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int k, w;
                logic e_busy, e_done, e_we, e_re;
                logic [7:0] e_addr;
                logic [31:0] e_dat;
                k = m_k[i]; w = wc(i);
                e_busy = (k >= 1) && (k < 5 + w);
                e_done = (k == 5 + w);
                e_we   = (k == 1) || (k == 2);
                e_re   = (k == 3 + w) || (k == 4 + w);
                e_addr = (k == 1) ? 8'h00 : (k == 2) ? 8'h04 :
                         (k == 3 + w) ? 8'h08 : (k == 4 + w) ? 8'h0c : 8'h00;
                e_dat  = (k == 1) ? {16'h0000, m_a[i]} : (k == 2) ? {16'h0000, m_b[i]} : 32'h0;
                vectors++;
                if (busy_s[i] !== e_busy || done_s[i] !== e_done || we_s[i] !== e_we ||
                    re_s[i] !== e_re || addr_s[i] !== e_addr || wdat_s[i] !== e_dat ||
                    res_s[i] !== m_res[i] || ovf_s[i] !== m_ovf[i]) begin
                    errors++;
                    $display("FAIL cycle_cmp dut%0d t=%0t got busy=%b done=%b addr=%h dat=%h we=%b re=%b res=%h ovf=%b want busy=%b done=%b addr=%h dat=%h we=%b re=%b res=%h ovf=%b",
                             i, $time, busy_s[i], done_s[i], addr_s[i], wdat_s[i], we_s[i], re_s[i],
                             res_s[i], ovf_s[i], e_busy, e_done, e_addr, e_dat, e_we, e_re,
                             m_res[i], m_ovf[i]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One transaction; optional start pulses in cycles 2 and 4 with junk operands.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic eo, input bit glitch);
        int c0, c1, ndone0, nwr0;
        c0 = 0; c1 = 0; ndone0 = 0; nwr0 = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_a_i = a; op_b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_a_i = ~a; op_b_i = b ^ 16'h5a5a;
        for (int c = 1; c <= 14; c++) begin
            if (done_s[0]) begin ndone0++; if (c0 == 0) c0 = c; end
            if (done_s[1] && c1 == 0) c1 = c;
            if (we_s[0]) nwr0++;
            start_i = glitch && (c == 2 || c == 4);
            op_a_i  = 16'h1234 + 16'(c);
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check("done_cycle_w2", 64'(c0), 64'd7);
        check("done_cycle_w0", 64'(c1), 64'd5);
        check("done_count_w2", 64'(ndone0), 64'd1);
        check("write_count_w2", 64'(nwr0), 64'd2);
        check("result_w2", 64'(res_s[0]), 64'(er));
        check("overflow_w2", 64'(ovf_s[0]), 64'(eo));
        check("result_w0", 64'(res_s[1]), 64'(er));
        check("overflow_w0", 64'(ovf_s[1]), 64'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0 [$];
        int d1 [$];
        int strobes;
        wb_rst_n = 1'b0; start_i = 1'b0; op_a_i = 16'h0; op_b_i = 16'h0;
        #2 chk_en = 1'b1;
        #20;
        check("reset_outputs", {busy_s[0], done_s[0], ovf_s[0], we_s[0], re_s[0], res_s[0], addr_s[0], wdat_s[0]}, 64'd0);
        @(posedge clk); #1;
        wb_rst_n = 1'b1;

        run_txn(16'd3, 16'd5, 16'd15, 1'b0, 1'b0);
        run_txn(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
        run_txn(16'd12, 16'd11, 16'd132, 1'b0, 1'b1);
        run_txn(16'd7, 16'd9, 16'd63, 1'b0, 1'b0);

        // start held high: back-to-back transactions
        @(posedge clk); #1;
        start_i = 1'b1; op_a_i = 16'd3; op_b_i = 16'd4;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done_s[0]) d0.push_back(c);
            if (done_s[1]) d1.push_back(c);
        end
        start_i = 1'b0;
        check("b2b_done_count_w2", 64'(d0.size() >= 3), 64'd1);
        check("b2b_done_count_w0", 64'(d1.size() >= 3), 64'd1);
        if (d0.size() >= 3) check("b2b_period_w2", 64'(d0[2] - d0[1]), 64'd7);
        if (d1.size() >= 3) check("b2b_period_w0", 64'(d1[2] - d1[1]), 64'd5);
        check("b2b_result", 64'(res_s[0]), 64'd12);
        repeat (10) begin @(posedge clk); #1; end

        // reset asserted while the W=2 master is in its settle phase
        start_i = 1'b1; op_a_i = 16'd100; op_b_i = 16'd200;
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", 64'(busy_s[0]), 64'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy_s[0], done_s[0], ovf_s[0], we_s[0], re_s[0], res_s[0], addr_s[0], wdat_s[0]}, 64'd0);
        #20;
        @(posedge clk); #1;
        wb_rst_n = 1'b1;
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (we_s[0] || re_s[0] || we_s[1] || re_s[1]) strobes++;
        end
        check("no_strobe_after_reset", 64'(strobes), 64'd0);

        run_txn(16'd7, 16'd9, 16'd63, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
